// File: rtl/sprite_anim_renderer.sv
`default_nettype none
// ============================================================================
// Module   : sprite_anim_renderer
// Brief    : Animated sprite pixel source: scaled/mirrored sprite over a
//            background with colour-key transparency, 3-stage pixel pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_anim_renderer #(
  parameter  int SPR_W      = 32,
  parameter  int SPR_H      = 32,
  parameter  int NUM_FRAMES = 4,
  parameter  int FRAME_DIV  = 8,
  parameter  int IDX_W      = 3,
  parameter  int TRANSP_IDX = 0,
  parameter  int ONESHOT    = 0,
  localparam int ADDR_W     = $clog2(NUM_FRAMES*SPR_W*SPR_H),
  localparam int FI_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        scale,
  input  logic              mirror_x,
  input  logic              anim_en,
  input  logic              anim_restart,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_idx,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [FI_W-1:0]   frame_idx,
  output logic              anim_done
);

  localparam int c_LX_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int c_LY_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int c_DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [0:0] {PLAY = 1'b0, DONE = 1'b1} state_t;

  state_t              r_state;
  logic [c_DIV_W-1:0]  r_div;
  logic [9:0]          r_drawy_q;
  logic                r_hit1, r_hit2, r_blank1, r_blank2;
  logic [11:0]         r_bg1, r_bg2;

  logic [11:0]         w_dx, w_dy, w_px, w_py, w_end_x, w_end_y, w_off_x, w_off_y;
  logic                w_hit, w_tick;
  logic [c_LX_W-1:0]   w_lx_raw, w_lx;
  logic [c_LY_W-1:0]   w_ly;
  logic [ADDR_W-1:0]   w_addr;

  // 12-bit arithmetic so a sprite hanging off the right/bottom edge is clipped, never wrapped
  assign w_dx    = {2'b00, DrawX};
  assign w_dy    = {2'b00, DrawY};
  assign w_px    = {2'b00, pos_x};
  assign w_py    = {2'b00, pos_y};
  assign w_end_x = w_px + (12'(SPR_W) << scale);
  assign w_end_y = w_py + (12'(SPR_H) << scale);
  assign w_hit   = (w_dx >= w_px) && (w_dx < w_end_x) && (w_dy >= w_py) && (w_dy < w_end_y);

  assign w_off_x  = w_dx - w_px;
  assign w_off_y  = w_dy - w_py;
  assign w_lx_raw = c_LX_W'(w_off_x >> scale);
  assign w_lx     = mirror_x ? (c_LX_W'(SPR_W - 1) - w_lx_raw) : w_lx_raw;
  assign w_ly     = c_LY_W'(w_off_y >> scale);
  assign w_addr   = ADDR_W'(frame_idx) * ADDR_W'(SPR_W*SPR_H)
                  + ADDR_W'(w_ly) * ADDR_W'(SPR_W) + ADDR_W'(w_lx);

  assign w_tick  = (r_drawy_q != 10'd0) && (DrawY == 10'd0);
  assign pal_idx = rom_q;

  // Pixel pipeline: S1 address/hit, S2 ROM access, S3 colour select
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      rom_addr  <= '0;
      r_hit1    <= 1'b0;
      r_blank1  <= 1'b0;
      r_bg1     <= 12'h000;
      r_hit2    <= 1'b0;
      r_blank2  <= 1'b0;
      r_bg2     <= 12'h000;
      red       <= 4'h0;
      green     <= 4'h0;
      blue      <= 4'h0;
      r_drawy_q <= 10'd0;
    end else begin
      r_drawy_q <= DrawY;
      r_hit1    <= w_hit;
      r_blank1  <= blank;
      r_bg1     <= {bg_red, bg_green, bg_blue};
      if (w_hit)
        rom_addr <= w_addr;
      r_hit2    <= r_hit1;
      r_blank2  <= r_blank1;
      r_bg2     <= r_bg1;
      if (!r_blank2)
        {red, green, blue} <= 12'h000;
      else if (r_hit2 && (rom_q != IDX_W'(TRANSP_IDX)))
        {red, green, blue} <= {pal_red, pal_green, pal_blue};
      else
        {red, green, blue} <= r_bg2;
    end
  end

  // Animation: frame_idx only moves on the vertical-wrap tick, so a frame never tears
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= PLAY;
      r_div     <= '0;
      frame_idx <= '0;
      anim_done <= 1'b0;
    end else if (anim_restart) begin
      r_state   <= PLAY;
      r_div     <= '0;
      frame_idx <= '0;
      anim_done <= 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_tick && anim_en) begin
            if (r_div == c_DIV_W'(FRAME_DIV - 1)) begin
              r_div <= '0;
              if (frame_idx == FI_W'(NUM_FRAMES - 1)) begin
                if (ONESHOT != 0) begin
                  anim_done <= 1'b1;
                  r_state   <= DONE;
                end else begin
                  frame_idx <= '0;
                end
              end else begin
                frame_idx <= frame_idx + FI_W'(1);
              end
            end else begin
              r_div <= r_div + c_DIV_W'(1);
            end
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: r_state <= PLAY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_anim_renderer
// Brief    : Randomised self-checking bench with an arithmetic reference model
//            for sprite rendering and frame animation (loop and one-shot).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_anim_renderer;
  localparam int SPR_W = 32, SPR_H = 32, NF = 4, FD = 2, TRANSP = 0;

  logic        vga_clk = 1'b0, Reset = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic        blank = 1'b0, mirror_x = 1'b0, anim_en = 1'b0, anim_restart = 1'b0;
  logic [1:0]  scale = '0;
  logic [3:0]  bg_red = '0, bg_green = '0, bg_blue = '0;
  logic [11:0] rom_addr, rom_addr_os;
  logic [2:0]  rom_q = '0, rom_q_os = '0, pal_idx, pal_idx_os;
  logic [3:0]  pal_red, pal_green, pal_blue, pal_red_os, pal_green_os, pal_blue_os;
  logic [3:0]  red, green, blue, red_os, green_os, blue_os;
  logic [1:0]  frame_idx, frame_idx_os;
  logic        anim_done, anim_done_os;

  logic [2:0]  rom_mem [4096];
  logic [11:0] exp_q[$];
  int          n_checks = 0, n_pass = 0;
  int          m_ticks = 0;

  sprite_anim_renderer #(.SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NF), .FRAME_DIV(FD),
                         .IDX_W(3), .TRANSP_IDX(TRANSP), .ONESHOT(0)) u_dut (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .mirror_x(mirror_x), .anim_en(anim_en),
    .anim_restart(anim_restart), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_idx(pal_idx), .pal_red(pal_red),
    .pal_green(pal_green), .pal_blue(pal_blue), .red(red), .green(green), .blue(blue),
    .frame_idx(frame_idx), .anim_done(anim_done));

  sprite_anim_renderer #(.SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NF), .FRAME_DIV(FD),
                         .IDX_W(3), .TRANSP_IDX(TRANSP), .ONESHOT(1)) u_dut_os (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .mirror_x(mirror_x), .anim_en(anim_en),
    .anim_restart(anim_restart), .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr_os), .rom_q(rom_q_os), .pal_idx(pal_idx_os), .pal_red(pal_red_os),
    .pal_green(pal_green_os), .pal_blue(pal_blue_os), .red(red_os), .green(green_os),
    .blue(blue_os), .frame_idx(frame_idx_os), .anim_done(anim_done_os));

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) begin
    rom_q    <= rom_mem[rom_addr];
    rom_q_os <= rom_mem[rom_addr_os];
  end

  function automatic logic [11:0] pal_of(logic [2:0] i);
    return {1'b1, i, i, 1'b0, ({1'b0, i} ^ 4'hA)};
  endfunction

  assign {pal_red, pal_green, pal_blue}          = pal_of(pal_idx);
  assign {pal_red_os, pal_green_os, pal_blue_os} = pal_of(pal_idx_os);

  function automatic int cur_frame();
    return (m_ticks / FD) % NF;
  endfunction

  // Reference: rectangle test and texel lookup in plain integer arithmetic
  function automatic logic [11:0] model_px(int dx, int dy, bit bl, int px, int py, int sc,
                                           bit mir, int frame, logic [11:0] bg);
    int mag, lx, ly;
    logic [2:0] idx;
    mag = 1 << sc;
    if (!bl) return 12'h000;
    if (dx < px || dx >= px + SPR_W*mag || dy < py || dy >= py + SPR_H*mag) return bg;
    lx = (dx - px) / mag;
    ly = (dy - py) / mag;
    if (mir) lx = SPR_W - 1 - lx;
    idx = rom_mem[frame*SPR_W*SPR_H + ly*SPR_W + lx];
    return (idx == TRANSP) ? bg : pal_of(idx);
  endfunction

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // Drive one pixel, clock it in, and compare the pixel issued two clocks earlier
  task automatic run_pixel(int dx, int dy, bit bl, int px, int py, int sc, bit mir,
                           logic [11:0] bg);
    logic [11:0] e;
    DrawX = 10'(dx); DrawY = 10'(dy); blank = bl; pos_x = 10'(px); pos_y = 10'(py);
    scale = 2'(sc); mirror_x = mir; {bg_red, bg_green, bg_blue} = bg;
    exp_q.push_back(model_px(dx, dy, bl, px, py, sc, mir, cur_frame(), bg));
    step();
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({red, green, blue} !== e)
        $display("FAIL rgb px(%0d,%0d): got %h expected %h", DrawX, DrawY, {red, green, blue}, e);
      else n_pass++;
    end
  endtask

  task automatic drain();
    repeat (2) run_pixel(0, 0, 1'b0, 0, 0, 0, 1'b0, 12'h000);
    exp_q.delete();
  endtask

  task automatic check_addr(string nm, logic [11:0] e);
    n_checks++;
    if (rom_addr !== e) $display("FAIL %s: rom_addr got %0d expected %0d", nm, rom_addr, e);
    else n_pass++;
  endtask

  task automatic check_anim(string nm);
    int steps;
    steps = m_ticks / FD;
    n_checks++;
    if (frame_idx !== 2'(steps % NF) || anim_done !== 1'b0)
      $display("FAIL %s loop: frame %0d done %0d expected %0d 0", nm, frame_idx, anim_done, steps % NF);
    else n_pass++;
    n_checks++;
    if (frame_idx_os !== 2'((steps < NF) ? steps : NF-1) || anim_done_os !== (steps >= NF))
      $display("FAIL %s oneshot: frame %0d done %0d expected %0d %0d", nm, frame_idx_os,
               anim_done_os, (steps < NF) ? steps : NF-1, steps >= NF);
    else n_pass++;
  endtask

  task automatic do_tick(bit restart);
    DrawY = 10'd7; step();
    DrawY = 10'd0; anim_restart = restart; step();
    anim_restart = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] bg;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 3'($urandom);
    for (int i = 0; i < 4; i++) begin
      DrawX = 10'($urandom); DrawY = 10'($urandom); blank = 1'b1;
      {bg_red, bg_green, bg_blue} = 12'($urandom);
      step();
      n_checks++;
      if ({red, green, blue} !== 12'h000) $display("FAIL reset_rgb: got %h expected 000", {red, green, blue});
      else n_pass++;
    end
    check_anim("reset_anim");
    check_addr("reset_addr", 12'd0);
    Reset = 1'b0;
    m_ticks = 0;
    bg = 12'h5A3;
    DrawX = 10'd10; DrawY = 10'd10; pos_x = 10'd1000; pos_y = 10'd1000; blank = 1'b1;
    {bg_red, bg_green, bg_blue} = bg;
    step(); step();
    n_checks++;
    if ({red, green, blue} !== 12'h000) $display("FAIL release_early: got %h expected 000", {red, green, blue});
    else n_pass++;
    step();
    n_checks++;
    if ({red, green, blue} !== bg) $display("FAIL release_bg: got %h expected %h", {red, green, blue}, bg);
    else n_pass++;
  endtask

  task automatic test_hit_edges();
    exp_q.delete();
    rom_mem[0] = 3'd5; rom_mem[31] = 3'd0;
    run_pixel(110, 51, 1'b1, 100, 50, 0, 1'b0, 12'h111); check_addr("hit_42", 12'd42);
    run_pixel(100, 50, 1'b1, 100, 50, 0, 1'b0, 12'h222); check_addr("hit_0", 12'd0);
    run_pixel(131, 50, 1'b1, 100, 50, 0, 1'b0, 12'h333); check_addr("hit_31", 12'd31);
    run_pixel(132, 50, 1'b1, 100, 50, 0, 1'b0, 12'h444); check_addr("nohit_hold", 12'd31);
    run_pixel(99, 50, 1'b1, 100, 50, 0, 1'b0, 12'h555);
    run_pixel(100, 82, 1'b1, 100, 50, 0, 1'b0, 12'h666);
    drain();
  endtask

  task automatic test_scale_mirror();
    rom_mem[30] = 3'(TRANSP);
    run_pixel(202, 100, 1'b1, 200, 100, 1, 1'b1, 12'h9C1); check_addr("mirror_30", 12'd30);
    drain();
    rom_mem[30] = 3'd6;
    run_pixel(202, 100, 1'b1, 200, 100, 1, 1'b1, 12'h9C1);
    run_pixel(203, 101, 1'b1, 200, 100, 1, 1'b1, 12'h9C2);
    run_pixel(263, 163, 1'b1, 200, 100, 1, 1'b1, 12'h9C3); check_addr("mirror_992", 12'd992);
    run_pixel(264, 163, 1'b1, 200, 100, 1, 1'b1, 12'h9C4);
    drain();
  endtask

  task automatic test_right_edge();
    run_pixel(639, 10, 1'b1, 620, 10, 0, 1'b0, 12'h0F0); check_addr("edge_19", 12'd19);
    run_pixel(619, 10, 1'b1, 620, 10, 0, 1'b0, 12'h0F1);
    run_pixel(630, 12, 1'b0, 620, 10, 0, 1'b0, 12'h0F2);
    run_pixel(5, 10, 1'b1, 1010, 10, 3, 1'b0, 12'h0F3);
    run_pixel(1023, 1023, 1'b1, 1010, 1000, 3, 1'b1, 12'h0F4);
    drain();
  endtask

  task automatic test_anim();
    anim_en = 1'b0;
    anim_restart = 1'b1; step(); anim_restart = 1'b0;
    m_ticks = 0;
    check_anim("restart");
    anim_en = 1'b1;
    for (int t = 0; t < 12; t++) begin
      do_tick(1'b0);
      m_ticks++;
      check_anim("tick");
    end
  endtask

  task automatic test_back_to_back();
    do_tick(1'b1);
    m_ticks = 0;
    check_anim("restart_on_tick");
    for (int t = 0; t < 5; t++) begin
      do_tick(1'b0);
      m_ticks++;
      check_anim("after_restart");
    end
    anim_en = 1'b0;
  endtask

  task automatic test_random_pixels();
    int px, py, dx, dy;
    exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      px = $urandom_range(0, 1023); py = $urandom_range(0, 1023);
      dx = px + $urandom_range(0, 300) - 20; dy = py + $urandom_range(0, 300) - 20;
      dx = (dx < 0) ? 0 : (dx > 1023) ? 1023 : dx;
      dy = (dy < 0) ? 0 : (dy > 1023) ? 1023 : dy;
      run_pixel(dx, dy, ($urandom % 8) != 0, px, py, $urandom_range(0, 3), 1'($urandom),
                12'($urandom));
    end
    drain();
  endtask

  task automatic test_disable_and_reset();
    anim_en = 1'b0;
    for (int t = 0; t < 5; t++) begin
      do_tick(1'b0);
      check_anim("anim_dis");
    end
    rom_mem[2*SPR_W*SPR_H + SPR_W + 1] = 3'd3;
    repeat (3) run_pixel(301, 301, 1'b1, 300, 300, 0, 1'b0, 12'h123);
    exp_q.delete();
    @(posedge vga_clk); #3;
    Reset = 1'b1;
    #1;
    m_ticks = 0;
    n_checks++;
    if ({red, green, blue} !== 12'h000 || rom_addr !== 12'd0)
      $display("FAIL async_reset: rgb %h addr %0d expected 000 0", {red, green, blue}, rom_addr);
    else n_pass++;
    check_anim("async_reset");
    step();
    Reset = 1'b0;
    repeat (3) run_pixel(50, 60, 1'b1, 900, 900, 0, 1'b0, 12'hBEE);
    run_pixel(50, 60, 1'b1, 900, 900, 0, 1'b0, 12'hBEE);
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2;
    test_reset();
    test_hit_edges();
    test_scale_mirror();
    test_right_edge();
    test_anim();
    test_back_to_back();
    test_random_pixels();
    test_disable_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
